// File: rtl/grid2axis_stream_pkg.sv
// Shared constants, FSM encoding and beat-count helpers for the grid-to-AXIS converter.
package grid2axis_stream_pkg;

  localparam int unsigned LAST_FRAME = 0;
  localparam int unsigned LAST_ROW   = 1;

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

  function automatic int unsigned calc_beats(int unsigned w, int unsigned h, int unsigned ppb);
    return (w * h) / ppb;
  endfunction

  function automatic int unsigned calc_row_beats(int unsigned w, int unsigned ppb);
    return w / ppb;
  endfunction

endpackage

// File: rtl/grid2axis_stream_pix_expand.sv
// Picks the PPB cells of one beat from a bank and maps each to its alive/dead colour.
module grid2axis_stream_pix_expand
  import grid2axis_stream_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CELLS  = 16,
  parameter int unsigned PPB    = 1,
  parameter int unsigned CW     = $clog2(CELLS)
) (
  input  logic [CELLS-1:0]      bank,
  input  logic [CW-1:0]         beat,
  input  logic [DWIDTH-1:0]     alive_color,
  input  logic [DWIDTH-1:0]     dead_color,
  output logic [DWIDTH*PPB-1:0] pix
);

  logic [CW-1:0] base;
  logic [CW-1:0] idx;

  always_comb begin
    pix  = '0;
    idx  = '0;
    base = beat * CW'(PPB);
    for (int p = 0; p < int'(PPB); p++) begin
      idx = base + CW'(p);
      pix[p*DWIDTH +: DWIDTH] = bank[idx] ? alive_color : dead_color;
    end
  end

endmodule

// File: rtl/grid2axis_stream.sv
// Ping-pong frame buffer that streams 1-bit cell frames as colour pixels over AXI4-Stream.
module grid2axis_stream
  import grid2axis_stream_pkg::*;
#(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned HEIGHT       = 4,
  parameter int unsigned PIX_PER_BEAT = 1,
  parameter int unsigned LAST_MODE    = LAST_FRAME
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [DWIDTH-1:0]              alive_color,
  input  logic [DWIDTH-1:0]              dead_color,
  input  logic [WIDTH*HEIGHT-1:0]        in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DWIDTH*PIX_PER_BEAT-1:0] M_AXIS_TDATA,
  output logic                           M_AXIS_TVALID,
  input  logic                           M_AXIS_TREADY,
  output logic                           M_AXIS_TLAST,
  output logic                           M_AXIS_TUSER,
  output logic [15:0]                    frames_sent
);

  localparam int unsigned Cells    = WIDTH * HEIGHT;
  localparam int unsigned Beats    = calc_beats(WIDTH, HEIGHT, PIX_PER_BEAT);
  localparam int unsigned RowBeats = calc_row_beats(WIDTH, PIX_PER_BEAT);
  localparam int unsigned BW       = $clog2(Beats) + 1;
  localparam int unsigned CW       = $clog2(Cells);
  localparam int unsigned OW       = DWIDTH * PIX_PER_BEAT;

  logic [Cells-1:0]  bank_q  [2];
  logic [DWIDTH-1:0] alive_q [2];
  logic [DWIDTH-1:0] dead_q  [2];
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, rd_sel_q, rd_sel_d;
  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [15:0]       frames_q, frames_d;
  logic              in_ready_q;
  logic              valid_q, valid_d;
  logic [OW-1:0]     data_q;
  logic              last_q, last_d, user_q, user_d;

  logic              capture, accept, final_beat;
  logic              load, load_sel;
  logic [BW-1:0]     load_beat;
  logic [OW-1:0]     pix;

  grid2axis_stream_pix_expand #(
    .DWIDTH (DWIDTH),
    .CELLS  (Cells),
    .PPB    (PIX_PER_BEAT),
    .CW     (CW)
  ) u_expand (
    .bank        (bank_q[load_sel]),
    .beat        (CW'(load_beat)),
    .alive_color (alive_q[load_sel]),
    .dead_color  (dead_q[load_sel]),
    .pix         (pix)
  );

  always_comb begin
    capture    = in_valid && in_ready_q;
    accept     = valid_q && M_AXIS_TREADY;
    final_beat = accept && (beat_q == BW'(Beats - 1));
    state_d    = state_q;
    beat_d     = beat_q;
    rd_sel_d   = rd_sel_q;
    frames_d   = frames_q;
    full_d     = full_q;
    valid_d    = valid_q;
    load       = 1'b0;
    load_sel   = rd_sel_q;
    load_beat  = beat_q;

    if (capture) full_d[wr_sel_q] = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (full_q[rd_sel_q]) begin
          load      = 1'b1;
          load_beat = '0;
          state_d   = StStream;
        end
      end
      StStream: begin
        if (final_beat) begin
          // Capture can only target the other bank here, so clearing rd_sel never aliases it.
          full_d[rd_sel_q] = 1'b0;
          rd_sel_d         = ~rd_sel_q;
          frames_d         = frames_q + 16'd1;
          beat_d           = '0;
          if (full_q[~rd_sel_q]) begin
            load      = 1'b1;
            load_sel  = ~rd_sel_q;
            load_beat = '0;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end else if (accept) begin
          load      = 1'b1;
          load_beat = beat_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      valid_d = 1'b1;
      beat_d  = load_beat;
    end
    user_d = (load_beat == '0);
    if (LAST_MODE == LAST_ROW) last_d = ((32'(load_beat) + 32'd1) % RowBeats) == 32'd0;
    else                       last_d = (load_beat == BW'(Beats - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      alive_q[0] <= '0;
      alive_q[1] <= '0;
      dead_q[0]  <= '0;
      dead_q[1]  <= '0;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      state_q    <= StIdle;
      beat_q     <= '0;
      frames_q   <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
    end else begin
      if (capture) begin
        bank_q[wr_sel_q]  <= in_data;
        alive_q[wr_sel_q] <= alive_color;
        dead_q[wr_sel_q]  <= dead_color;
        wr_sel_q          <= ~wr_sel_q;
      end
      full_q     <= full_d;
      rd_sel_q   <= rd_sel_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      frames_q   <= frames_d;
      in_ready_q <= ~&full_d;
      valid_q    <= valid_d;
      if (load) begin
        data_q <= pix;
        last_q <= last_d;
        user_q <= user_d;
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign M_AXIS_TDATA  = data_q;
  assign M_AXIS_TVALID = valid_q;
  assign M_AXIS_TLAST  = last_q;
  assign M_AXIS_TUSER  = user_q;
  assign frames_sent   = frames_q;

endmodule

// File: tb/tb_grid2axis_stream.sv
// Directed and randomised-backpressure bench for grid2axis_stream (two parameter sets).
module tb_grid2axis_stream;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] alive = '0, dead = '0;
  logic [15:0] in_data0 = '0, in_data1 = '0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0, tready0 = 1'b0, tready1 = 1'b0;
  logic        in_ready0, in_ready1, tvalid0, tvalid1, tlast0, tlast1, tuser0, tuser1;
  logic [31:0] tdata0;
  logic [63:0] tdata1;
  logic [15:0] frames0, frames1;
  logic [15:0] exp_frames0 = '0;
  int          checks = 0, passes = 0;

  always #5 clk = ~clk;

  grid2axis_stream #(
    .DWIDTH(32), .WIDTH(4), .HEIGHT(4), .PIX_PER_BEAT(1), .LAST_MODE(0)
  ) dut0 (
    .clk(clk), .rstn(rstn), .alive_color(alive), .dead_color(dead),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .M_AXIS_TDATA(tdata0), .M_AXIS_TVALID(tvalid0), .M_AXIS_TREADY(tready0),
    .M_AXIS_TLAST(tlast0), .M_AXIS_TUSER(tuser0), .frames_sent(frames0)
  );

  grid2axis_stream #(
    .DWIDTH(32), .WIDTH(4), .HEIGHT(4), .PIX_PER_BEAT(2), .LAST_MODE(1)
  ) dut1 (
    .clk(clk), .rstn(rstn), .alive_color(alive), .dead_color(dead),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .M_AXIS_TDATA(tdata1), .M_AXIS_TVALID(tvalid1), .M_AXIS_TREADY(tready1),
    .M_AXIS_TLAST(tlast1), .M_AXIS_TUSER(tuser1), .frames_sent(frames1)
  );

  function automatic logic [31:0] px(input logic [15:0] f, input int c,
                                     input logic [31:0] a, input logic [31:0] d);
    return f[c] ? a : d;
  endfunction

  task automatic send0(input logic [15:0] f, input logic [31:0] a, input logic [31:0] d,
                       output bit ok);
    int n = 0;
    in_data0 = f; alive = a; dead = d; in_valid0 = 1'b1;
    while (!in_ready0 && n < 1000) begin @(posedge clk); #1; n++; end
    ok = in_ready0;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic recv0(output logic [31:0] d, output logic u, output logic l, output bit ok);
    int n = 0;
    while (!(tvalid0 && tready0) && n < 1000) begin @(posedge clk); #1; n++; end
    ok = tvalid0 && tready0;
    d = tdata0; u = tuser0; l = tlast0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({tvalid0, tuser0, tlast0, in_ready0, tdata0, frames0} !== 52'd0)
      $display("FAIL reset_outputs got valid=%b user=%b last=%b rdy=%b data=%h frames=%0d want all 0",
               tvalid0, tuser0, tlast0, in_ready0, tdata0, frames0);
    else passes++;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1)
      $display("FAIL reset_release_ready got %b/%b want 1/1", in_ready0, in_ready1);
    else passes++;
  endtask

  task automatic test_basic();
    logic [31:0] d; logic u, l; bit ok;
    tready0 = 1'b1;
    send0(16'h8001, 32'hFFFF_FFFF, 32'h0, ok);
    checks++; if (!ok) $display("FAIL basic_send got ready=0 want 1"); else passes++;
    for (int k = 0; k < 16; k++) begin
      recv0(d, u, l, ok);
      checks++;
      if (!ok || {d, u, l} !== {px(16'h8001, k, 32'hFFFF_FFFF, 32'h0), k == 0, k == 15})
        $display("FAIL basic_beat%0d got ok=%0b data=%h user=%b last=%b want data=%h user=%b last=%b",
                 k, ok, d, u, l, px(16'h8001, k, 32'hFFFF_FFFF, 32'h0), k == 0, k == 15);
      else passes++;
    end
    exp_frames0 = exp_frames0 + 16'd1;
    checks++;
    if (frames0 !== exp_frames0 || tvalid0 !== 1'b0)
      $display("FAIL basic_done got frames=%0d valid=%b want frames=%0d valid=0",
               frames0, tvalid0, exp_frames0);
    else passes++;
  endtask

  task automatic test_row_last();
    int n = 0;
    logic [63:0] e;
    alive = 32'hFFFF_FFFF; dead = 32'h0; in_data1 = 16'h00F0; in_valid1 = 1'b1; tready1 = 1'b1;
    while (!in_ready1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!tvalid1 && n < 100) begin @(posedge clk); #1; n++; end
      e = {px(16'h00F0, 2 * k + 1, 32'hFFFF_FFFF, 32'h0), px(16'h00F0, 2 * k, 32'hFFFF_FFFF, 32'h0)};
      checks++;
      if ({tvalid1, tdata1, tuser1, tlast1} !== {1'b1, e, k == 0, (k % 2) == 1})
        $display("FAIL row_beat%0d got valid=%b data=%h user=%b last=%b want valid=1 data=%h user=%b last=%b",
                 k, tvalid1, tdata1, tuser1, tlast1, e, k == 0, (k % 2) == 1);
      else passes++;
      @(posedge clk); #1;
    end
    checks++;
    if (frames1 !== 16'd1) $display("FAIL row_frames got %0d want 1", frames1); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic u, l; bit ok;
    tready0 = 1'b1;
    send0(16'h1234, 32'h1111_1111, 32'h2222_2222, ok);
    send0(16'hC3C2, 32'h3333_3333, 32'h4444_4444, ok);
    checks++; if (!ok) $display("FAIL b2b_send got ready=0 want 1"); else passes++;
    for (int k = 0; k < 16; k++) begin
      recv0(d, u, l, ok);
      checks++;
      if (!ok || {d, l} !== {px(16'h1234, k, 32'h1111_1111, 32'h2222_2222), k == 15})
        $display("FAIL b2b_a_beat%0d got data=%h last=%b want data=%h last=%b",
                 k, d, l, px(16'h1234, k, 32'h1111_1111, 32'h2222_2222), k == 15);
      else passes++;
    end
    checks++;
    if ({tvalid0, tuser0, tdata0} !== {1'b1, 1'b1, 32'h4444_4444})
      $display("FAIL b2b_no_gap got valid=%b user=%b data=%h want valid=1 user=1 data=44444444",
               tvalid0, tuser0, tdata0);
    else passes++;
    for (int k = 0; k < 16; k++) begin
      recv0(d, u, l, ok);
      checks++;
      if (!ok || {d, u, l} !== {px(16'hC3C2, k, 32'h3333_3333, 32'h4444_4444), k == 0, k == 15})
        $display("FAIL b2b_b_beat%0d got data=%h user=%b last=%b want data=%h",
                 k, d, u, l, px(16'hC3C2, k, 32'h3333_3333, 32'h4444_4444));
      else passes++;
    end
    exp_frames0 = exp_frames0 + 16'd2;
    checks++;
    if (frames0 !== exp_frames0) $display("FAIL b2b_frames got %0d want %0d", frames0, exp_frames0);
    else passes++;
  endtask

  task automatic test_stall();
    logic [31:0] d; logic u, l; bit ok;
    tready0 = 1'b0;
    send0(16'h0001, 32'hCAFE_BABE, 32'h0, ok);
    send0(16'hFFFE, 32'h1234_5678, 32'h8765_4321, ok);
    in_data0 = 16'h8000; alive = 32'h0F0F_0F0F; dead = 32'hF0F0_F0F0; in_valid0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({in_ready0, tvalid0, tuser0} !== 3'b011)
      $display("FAIL stall_full got ready=%b valid=%b user=%b want 0/1/1", in_ready0, tvalid0, tuser0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tdata0 !== 32'hCAFE_BABE) $display("FAIL stall_hold%0d got %h want cafebabe", i, tdata0);
      else passes++;
      @(posedge clk); #1;
    end
    tready0 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      recv0(d, u, l, ok);
      checks++;
      if (!ok || d !== px(16'h0001, k, 32'hCAFE_BABE, 32'h0))
        $display("FAIL stall_a_beat%0d got %h want %h", k, d, px(16'h0001, k, 32'hCAFE_BABE, 32'h0));
      else passes++;
    end
    checks++;
    if ({in_ready0, tvalid0, tuser0, tdata0} !== {3'b111, 32'h8765_4321})
      $display("FAIL stall_release got ready=%b valid=%b user=%b data=%h want 1/1/1 87654321",
               in_ready0, tvalid0, tuser0, tdata0);
    else passes++;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    checks++;
    if (in_ready0 !== 1'b0) $display("FAIL stall_c_captured got ready=%b want 0", in_ready0);
    else passes++;
    for (int k = 1; k < 16; k++) begin
      recv0(d, u, l, ok);
      checks++;
      if (!ok || d !== px(16'hFFFE, k, 32'h1234_5678, 32'h8765_4321))
        $display("FAIL stall_b_beat%0d got %h want %h", k, d, px(16'hFFFE, k, 32'h1234_5678, 32'h8765_4321));
      else passes++;
    end
    for (int k = 0; k < 16; k++) begin
      recv0(d, u, l, ok);
      checks++;
      if (!ok || {d, u, l} !== {px(16'h8000, k, 32'h0F0F_0F0F, 32'hF0F0_F0F0), k == 0, k == 15})
        $display("FAIL stall_c_beat%0d got %h want %h", k, d, px(16'h8000, k, 32'h0F0F_0F0F, 32'hF0F0_F0F0));
      else passes++;
    end
    exp_frames0 = exp_frames0 + 16'd3;
    checks++;
    if (frames0 !== exp_frames0) $display("FAIL stall_frames got %0d want %0d", frames0, exp_frames0);
    else passes++;
  endtask

  task automatic test_random();
    logic [15:0] qf[$];
    logic [31:0] qa[$], qd[$];
    int sent = 0, rcvd = 0, beat = 0, cyc = 0;
    bit cap;
    logic [31:0] e;
    in_data0 = 16'($urandom); alive = $urandom; dead = $urandom; in_valid0 = 1'b1;
    tready0 = 1'($urandom % 2);
    while (rcvd < 100 && cyc < 20000) begin
      cap = in_valid0 && in_ready0;
      if (cap) begin qf.push_back(in_data0); qa.push_back(alive); qd.push_back(dead); sent++; end
      if (tvalid0) begin
        checks++;
        if (qf.size() == 0) begin
          $display("FAIL rand_unexpected_beat got valid=1 want no frame pending");
        end else begin
          e = px(qf[0], beat, qa[0], qd[0]);
          if ({tdata0, tuser0, tlast0} !== {e, beat == 0, beat == 15})
            $display("FAIL rand_beat f=%0d b=%0d got data=%h user=%b last=%b want data=%h user=%b last=%b",
                     rcvd, beat, tdata0, tuser0, tlast0, e, beat == 0, beat == 15);
          else passes++;
          if (tready0) begin
            beat++;
            if (beat == 16) begin
              beat = 0; rcvd++;
              void'(qf.pop_front()); void'(qa.pop_front()); void'(qd.pop_front());
            end
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cap) begin in_data0 = 16'($urandom); in_valid0 = (sent < 100); end
      alive = $urandom; dead = $urandom;
      tready0 = 1'($urandom % 2);
    end
    in_valid0 = 1'b0;
    tready0 = 1'b1;
    exp_frames0 = exp_frames0 + 16'd100;
    checks++;
    if (rcvd != 100 || frames0 !== exp_frames0)
      $display("FAIL rand_frames got rcvd=%0d frames=%0d want rcvd=100 frames=%0d",
               rcvd, frames0, exp_frames0);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic u, l; bit ok;
    tready0 = 1'b1;
    send0(16'hA5C3, 32'hFFFF_0000, 32'h0000_FFFF, ok);
    for (int k = 0; k < 7; k++) recv0(d, u, l, ok);
    checks++;
    if ({tvalid0, tdata0} !== {1'b1, px(16'hA5C3, 7, 32'hFFFF_0000, 32'h0000_FFFF)})
      $display("FAIL rmid_beat7 got valid=%b data=%h want valid=1 data=%h",
               tvalid0, tdata0, px(16'hA5C3, 7, 32'hFFFF_0000, 32'h0000_FFFF));
    else passes++;
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({tvalid0, in_ready0, frames0} !== 18'd0)
      $display("FAIL rmid_async got valid=%b ready=%b frames=%0d want 0/0/0", tvalid0, in_ready0, frames0);
    else passes++;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_frames0 = '0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready0, tvalid0} !== 2'b10) $display("FAIL rmid_release got ready=%b valid=%b want 1/0", in_ready0, tvalid0);
    else passes++;
    send0(16'h0003, 32'hABCD_EF01, 32'h0, ok);
    recv0(d, u, l, ok);
    checks++;
    if (!ok || {d, u, frames0} !== {32'hABCD_EF01, 1'b1, 16'd0})
      $display("FAIL rmid_restart got data=%h user=%b frames=%0d want abcdef01/1/0", d, u, frames0);
    else passes++;
    for (int k = 1; k < 16; k++) recv0(d, u, l, ok);
    exp_frames0 = exp_frames0 + 16'd1;
    checks++;
    if ({d, l, frames0} !== {32'h0, 1'b1, exp_frames0})
      $display("FAIL rmid_end got data=%h last=%b frames=%0d want 0/1/%0d", d, l, frames0, exp_frames0);
    else passes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_row_last();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
